// File: rtl/fft_pass_sched.sv
// Frame scheduler for the shared FFT datapath: accepts one frame from s_p, runs
// the butterfly for STEPS passes through reg1 and hands the last pass to p_s.
module fft_pass_sched #(
  parameter int STEPS = 3,
  parameter int ROT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             frame_valid,
  output logic             frame_ready,
  input  logic             out_ready,
  output logic             mux_flag,
  output logic [ROT_W-1:0] rotation,
  output logic             demux_flag,
  output logic             ps_load,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, PASS, LAST} state_t;

  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(STEPS - 1);
  localparam logic [ROT_W-1:0] ROT_PRE  = ROT_W'(STEPS - 2);

  state_t           state, state_next;
  logic [ROT_W-1:0] p, p_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // rst_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      p     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      p     <= p_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    p_next      = p;
    cnt_next    = cnt;
    frame_ready = 1'b0;
    mux_flag    = 1'b0;
    rotation    = '0;
    demux_flag  = 1'b0;
    ps_load     = 1'b0;
    busy        = 1'b0;
    if (!rst_n) begin
      unique case (state)
        IDLE: begin
          // the accept cycle doubles as pass 0, so reg1 captures it right away
          frame_ready = en;
          demux_flag  = frame_valid & en;
          if (frame_valid && en) begin
            p_next     = ROT_W'(1);
            state_next = (STEPS == 2) ? LAST : PASS;
          end
        end
        PASS: begin
          mux_flag   = 1'b1;
          rotation   = p;
          demux_flag = 1'b1;
          busy       = 1'b1;
          p_next     = p + ROT_W'(1);
          if (p == ROT_PRE) state_next = LAST;
        end
        LAST: begin
          // reg1 stays frozen so the butterfly output is stable while p_s waits
          mux_flag = 1'b1;
          rotation = ROT_LAST;
          ps_load  = out_ready;
          busy     = 1'b1;
          if (out_ready) begin
            cnt_next   = cnt + CNT_W'(1);
            p_next     = '0;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign frame_cnt = cnt;

endmodule

// File: tb/tb_fft_pass_sched.sv
// Scoreboard bench for fft_pass_sched: a pass-index reference model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_fft_pass_sched;

  localparam int STEPS = 3;
  localparam int ROT_W = 3;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b0;
  logic             frame_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             frame_ready;
  logic             mux_flag;
  logic [ROT_W-1:0] rotation;
  logic             demux_flag;
  logic             ps_load;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int fr;
    int mux;
    int rot;
    int demux;
    int ps;
    int busy;
    int cnt;
  } exp_t;

  exp_t sb_q[$];

  // reference model: whether a frame is in flight, which pass it is on, frames done
  bit m_busy = 1'b0;
  int m_pass = 0;
  int m_cnt  = 0;
  bit stim_done = 1'b0;

  fft_pass_sched #(.STEPS(STEPS), .ROT_W(ROT_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .out_ready(out_ready),
    .mux_flag(mux_flag),
    .rotation(rotation),
    .demux_flag(demux_flag),
    .ps_load(ps_load),
    .busy(busy),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input int req);
    checks++;
    if (act !== 32'(req)) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // drive one cycle of inputs, predict that cycle's outputs, then advance the model
  task automatic apply_stimulus(input bit r, input bit e, input bit fv, input bit ordy);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n       = r;
    en          = e;
    frame_valid = fv;
    out_ready   = ordy;
    #1;
    x = '{fr: 0, mux: 0, rot: 0, demux: 0, ps: 0, busy: 0, cnt: m_cnt % (1 << CNT_W)};
    if (!r) begin
      if (!m_busy) begin
        x.fr    = e;
        x.demux = fv & e;
      end else begin
        x.mux   = 1;
        x.rot   = m_pass;
        x.busy  = 1;
        x.demux = (m_pass < STEPS - 1) ? 1 : 0;
        x.ps    = (m_pass == STEPS - 1 && ordy) ? 1 : 0;
      end
    end
    sb_q.push_back(x);
    if (r) begin
      m_busy = 1'b0;
      m_pass = 0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (fv && e) begin
        m_busy = 1'b1;
        m_pass = 1;
      end
    end else if (m_pass < STEPS - 1) begin
      m_pass++;
    end else if (ordy) begin
      m_busy = 1'b0;
      m_pass = 0;
      m_cnt++;
    end
  endtask

  // monitor: every cycle the DUT presents a full output vector, compared mid-cycle
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t x;
      x = sb_q.pop_front();
      check_output("frame_ready", 32'(frame_ready), x.fr);
      check_output("mux_flag",    32'(mux_flag),    x.mux);
      check_output("rotation",    32'(rotation),    x.rot);
      check_output("demux_flag",  32'(demux_flag),  x.demux);
      check_output("ps_load",     32'(ps_load),     x.ps);
      check_output("busy",        32'(busy),        x.busy);
      check_output("frame_cnt",   32'(frame_cnt),   x.cnt);
      check_output("inv_demux_and_ps", 32'(demux_flag & ps_load), 0);
      check_output("inv_rot_range", 32'(int'(rotation) >= STEPS), 0);
      check_output("inv_ps_only_busy", 32'(ps_load & ~busy), 0);
    end
  end

  initial begin
    // reset held with a frame offered: everything stays quiet
    repeat (3) apply_stimulus(1, 1, 1, 0);

    // single frame, p_s always ready
    apply_stimulus(0, 1, 1, 1);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);

    // backpressure: LAST held for five cycles
    apply_stimulus(0, 1, 1, 0);
    apply_stimulus(0, 0, 0, 0);
    repeat (5) apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);

    // back-to-back frames
    repeat (4 * STEPS) apply_stimulus(0, 1, 1, 1);
    apply_stimulus(0, 0, 0, 1);

    // gating: en low blocks acceptance; en dropping mid-frame does not
    repeat (4) apply_stimulus(0, 0, 1, 1);
    apply_stimulus(0, 1, 1, 1);
    apply_stimulus(0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);

    // reset in the middle of a frame discards it
    apply_stimulus(0, 1, 1, 1);
    apply_stimulus(1, 1, 1, 1);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);

    // randomized traffic with occasional resets
    repeat (600) begin
      apply_stimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
    end

    // drive enough continuous frames to wrap frame_cnt
    apply_stimulus(1, 0, 0, 0);
    repeat (((1 << CNT_W) + 4) * STEPS) apply_stimulus(0, 1, 1, 1);
    repeat (2) apply_stimulus(0, 0, 0, 1);

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    stim_done = 1'b1;
    check_output("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard time bound in case the run ever stalls
  initial begin
    #2000000;
    if (!stim_done) begin
      $display("[TB] FAIL timeout: stimulus incomplete, got 0, expected 1");
      $fatal(1, "[TB] timeout");
    end
  end

endmodule
